// File: rtl/pc_sequencer.sv
// Program-counter sequencer between instruction decode and instruction memory.
// Chooses the next PC: sequential, relative branch, lookup-table jump, or halt.
module pc_sequencer #(
    parameter int D  = 12,
    parameter int OW = 8,
    parameter int LW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          stall,
    input  logic          branch_en,
    input  logic [OW-1:0] branch_offset,
    input  logic          absjump_en,
    input  logic [LW-1:0] lut_idx,
    input  logic          halt_req,
    output logic          lut_rd_en,
    output logic [LW-1:0] lut_addr,
    input  logic [D-1:0]  lut_data,
    output logic [D-1:0]  pc,
    output logic          fetch_valid,
    output logic          done
);

    // state     | meaning
    // S_IDLE    | out of reset, waiting for start
    // S_RUN     | fetching; decode controls sampled when not stalled
    // S_LUTWAIT | lookup-table read in flight, capture lut_data next edge
    // S_HALTED  | halt instruction seen, done held until restart
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_LUTWAIT = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [D-1:0]    pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            lut_rd_en_q, lut_rd_en_d;
    logic [LW-1:0]   lut_addr_q, lut_addr_d;
    logic            done_q, done_d;

    logic [D-1:0]    offset_ext;
    logic [D-1:0]    pc_seq;
    logic [D-1:0]    pc_branch;
    logic            decode_ok;

    assign offset_ext = {{(D-OW){branch_offset[OW-1]}}, branch_offset};
    assign pc_seq     = pc_q + {{(D-1){1'b0}}, 1'b1};
    assign pc_branch  = pc_q + offset_ext;
    assign decode_ok  = fetch_valid_q && !stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        lut_rd_en_d   = 1'b0;
        lut_addr_d    = lut_addr_q;
        done_d        = done_q;

        case (state_q)
            S_IDLE: begin
                fetch_valid_d = 1'b0;
                if (start) begin
                    state_d       = S_RUN;
                    pc_d          = '0;
                    fetch_valid_d = 1'b1;
                end
            end

            S_RUN: begin
                if (decode_ok) begin
                    if (halt_req) begin
                        state_d       = S_HALTED;
                        done_d        = 1'b1;
                        fetch_valid_d = 1'b0;
                    end else if (absjump_en) begin
                        state_d       = S_LUTWAIT;
                        lut_rd_en_d   = 1'b1;
                        lut_addr_d    = lut_idx;
                        fetch_valid_d = 1'b0;
                    end else if (branch_en) begin
                        pc_d = pc_branch;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end

            // The table word is only valid this one cycle, so stall cannot hold it off.
            S_LUTWAIT: begin
                state_d       = S_RUN;
                pc_d          = lut_data;
                fetch_valid_d = 1'b1;
            end

            S_HALTED: begin
                done_d        = 1'b1;
                fetch_valid_d = 1'b0;
                if (start) begin
                    state_d       = S_RUN;
                    pc_d          = '0;
                    done_d        = 1'b0;
                    fetch_valid_d = 1'b1;
                end
            end

            default: begin
                state_d       = S_IDLE;
                pc_d          = '0;
                fetch_valid_d = 1'b0;
                done_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            fetch_valid_q <= 1'b0;
            lut_rd_en_q   <= 1'b0;
            lut_addr_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            lut_rd_en_q   <= lut_rd_en_d;
            lut_addr_q    <= lut_addr_d;
            done_q        <= done_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign lut_rd_en   = lut_rd_en_q;
    assign lut_addr    = lut_addr_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver steps a behavioural model and queues
// the expected outputs; an independent monitor pops and compares after each edge.
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic        stall;
    logic        branch_en;
    logic [7:0]  branch_offset;
    logic        absjump_en;
    logic [4:0]  lut_idx;
    logic        halt_req;
    logic        lut_rd_en;
    logic [4:0]  lut_addr;
    logic [11:0] lut_data;
    logic [11:0] pc;
    logic        fetch_valid;
    logic        done;

    pc_sequencer #(.D(12), .OW(8), .LW(5)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .start         (start),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .absjump_en    (absjump_en),
        .lut_idx       (lut_idx),
        .halt_req      (halt_req),
        .lut_rd_en     (lut_rd_en),
        .lut_addr      (lut_addr),
        .lut_data      (lut_data),
        .pc            (pc),
        .fetch_valid   (fetch_valid),
        .done          (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] pc;
        logic        fv;
        logic        rd;
        logic [4:0]  addr;
        logic        done;
    } exp_t;

    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: spec-level mode plus architectural registers.
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;
    int          m_mode;
    int          m_pc;
    int          m_idx;
    int          m_addr;
    bit          m_done;
    logic [11:0] lut_mem [32];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_pc   = 0;
        m_idx  = 0;
        m_addr = 0;
        m_done = 0;
    endfunction

    function automatic int add_mod(int a, int b);
        int t;
        t = (a + b) % 4096;
        if (t < 0) t += 4096;
        return t;
    endfunction

    function automatic void model_step(bit s, bit st, bit br, logic [7:0] off,
                                       bit ab, logic [4:0] idx, bit h);
        int o;
        o = int'(off);
        if (o >= 128) o -= 256;
        case (m_mode)
            M_IDLE: if (s) begin m_mode = M_RUN; m_pc = 0; end
            M_RUN: begin
                if (!st) begin
                    if (h) begin
                        m_mode = M_HALT;
                        m_done = 1;
                    end else if (ab) begin
                        m_mode = M_WAIT;
                        m_idx  = int'(idx);
                        m_addr = int'(idx);
                    end else if (br) begin
                        m_pc = add_mod(m_pc, o);
                    end else begin
                        m_pc = add_mod(m_pc, 1);
                    end
                end
            end
            M_WAIT: begin
                m_pc   = int'(lut_mem[m_idx]);
                m_mode = M_RUN;
            end
            default: if (s) begin m_mode = M_RUN; m_pc = 0; m_done = 0; end
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.pc   = 12'(m_pc);
        e.fv   = (m_mode == M_RUN);
        e.rd   = (m_mode == M_WAIT);
        e.addr = 5'(m_addr);
        e.done = m_done;
        return e;
    endfunction

    task automatic cyc(input bit s, input bit st, input bit br, input logic [7:0] off,
                       input bit ab, input logic [4:0] idx, input bit h);
        @(negedge Clk);
        start         = s;
        stall         = st;
        branch_en     = br;
        branch_offset = off;
        absjump_en    = ab;
        lut_idx       = idx;
        halt_req      = h;
        lut_data      = (m_mode == M_WAIT) ? lut_mem[m_idx] : 12'($urandom);
        if (!Reset) model_reset();
        else        model_step(s, st, br, off, ab, idx, h);
        exp_q.push_back(model_out());
    endtask

    task automatic seq_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0, 5'd0, 0);
    endtask

    task automatic branch(input logic [7:0] off);
        cyc(0, 0, 1, off, 0, 5'd0, 0);
    endtask

    // Reset asserted between clock edges, checked before any edge can occur.
    task automatic async_reset(input string tag);
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk({tag, "_pc"},    32'(pc), 32'h0);
        chk({tag, "_fv"},    32'(fetch_valid), 32'h0);
        chk({tag, "_rd"},    32'(lut_rd_en), 32'h0);
        chk({tag, "_addr"},  32'(lut_addr), 32'h0);
        chk({tag, "_done"},  32'(done), 32'h0);
        model_reset();
        #1;
        Reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",          32'(pc),          32'(e.pc));
                chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
                chk("lut_rd_en",   32'(lut_rd_en),   32'(e.rd));
                chk("lut_addr",    32'(lut_addr),    32'(e.addr));
                chk("done",        32'(done),        32'(e.done));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        Reset         = 1'b0;
        start         = 1'b0;
        stall         = 1'b0;
        branch_en     = 1'b0;
        branch_offset = 8'h00;
        absjump_en    = 1'b0;
        lut_idx       = 5'd0;
        halt_req      = 1'b0;
        lut_data      = 12'h000;
        for (int i = 0; i < 32; i++) lut_mem[i] = 12'($urandom);
        lut_mem[3] = 12'h345;
        lut_mem[5] = 12'h030;
        model_reset();

        async_reset("rst0");
        seq_n(2);                              // idle without start

        cyc(1, 0, 0, 8'h00, 0, 5'd0, 0);       // start -> pc 0
        seq_n(4);                              // 1..4
        branch(8'hFB);                         // 4 - 5 -> 0xFFF
        seq_n(1);                              // wrap to 0x000
        branch(8'h10);                         // 0x010
        branch(8'hFB);                         // 0x00B
        branch(8'h07);                         // 0x012
        branch(8'hEC);                         // 0xFFE
        branch(8'h05);                         // 0x003
        branch(8'h00);                         // self-loop
        branch(8'h1D);                         // 0x020

        cyc(0, 0, 0, 8'h00, 1, 5'd3, 0);       // absjump idx 3
        cyc(0, 1, 0, 8'h00, 0, 5'd0, 0);       // LUTWAIT with stall -> 0x345
        cyc(0, 0, 0, 8'h00, 1, 5'd5, 0);
        cyc(0, 0, 1, 8'h7F, 1, 5'd9, 1);       // decode ignored in LUTWAIT -> 0x030
        cyc(0, 1, 1, 8'h01, 1, 5'd4, 1);       // stalled: nothing changes
        cyc(0, 0, 1, 8'h01, 1, 5'd4, 1);       // halt wins
        cyc(0, 0, 0, 8'h00, 0, 5'd0, 0);
        cyc(0, 0, 1, 8'h03, 1, 5'd2, 0);       // halted ignores decode
        cyc(1, 0, 0, 8'h00, 0, 5'd0, 0);       // restart
        seq_n(5);                              // pc 5
        cyc(1, 0, 0, 8'h00, 0, 5'd0, 0);       // start ignored in RUN -> 6

        cyc(0, 0, 0, 8'h00, 1, 5'd7, 0);       // into LUTWAIT
        async_reset("rst_mid_jump");
        seq_n(3);                              // must stay IDLE
        cyc(1, 0, 0, 8'h00, 0, 5'd0, 0);

        for (int i = 0; i < 32; i++) lut_mem[i] = 12'($urandom);
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) == 0,
                8'($urandom),
                $urandom_range(0, 9) == 0,
                5'($urandom),
                $urandom_range(0, 24) == 0);
        end

        @(posedge Clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
